// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product_bcd_converter slice.
//   state_t    : converter FSM states (binary, 2 bits)
//   DIGIT_W    : width of one packed BCD digit
//   ADJ_THRESH : digit value at or above which the add-3 correction applies
//   ADJ_CORR   : correction added before each shift
package product_bcd_converter_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_CORR   = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/product_bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction for one BCD digit.
//   din  : scratch digit before the shift
//   dout : din + 3 when din >= 5, otherwise din unchanged
// Purely combinational; never carries into a neighbouring digit.
module bcd_digit_adjust
  import product_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = (din >= ADJ_THRESH) ? din + ADJ_CORR : din;
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// for the 8-bit multiplier product.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   start : conversion request, accepted only while ready
//   bin   : binary value, captured on the accepting edge
//   ready : idle and able to accept start
//   busy  : conversion in progress
//   valid : one-cycle pulse, bcd holds a new result
//   bcd   : packed BCD result, digit 0 (units) in bits [3:0]
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic                      ready,
  output logic                      busy,
  output logic                      valid,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   binreg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adjusted;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [BCD_W-1:0]   scratch_n;
  logic [WIDTH-1:0]   binreg_n;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scratch[g*DIGIT_W +: DIGIT_W]),
      .dout (adjusted[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Whole {scratch, binreg} shifts as one vector so the top binary bit
  // enters the units digit; the adjusted MSB simply falls off the top.
  always_comb begin
    shifted = {adjusted, binreg} << 1;
  end

  assign scratch_n = shifted[BCD_W+WIDTH-1 -: BCD_W];
  assign binreg_n  = shifted[WIDTH-1:0];

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      binreg  <= '0;
      scratch <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            binreg  <= bin;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_n;
          binreg  <= binreg_n;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd   <= scratch_n;
            busy  <= 1'b0;
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [11:0] bcd;

  int pass_cnt;
  int total_cnt;

  product_bcd_converter #(
    .WIDTH  (8),
    .DIGITS (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .valid (valid),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Runs one conversion from IDLE and reports what was observed.
  task automatic convert(input logic [7:0] v, output logic [11:0] res,
                         output int lat, output int busy_cnt, output logic post_ok);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = ~v;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
    res = bcd;
    tick();
    post_ok = (ready === 1'b1) && (busy === 1'b0) && (valid === 1'b0);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    #12;
    total_cnt++;
    if ({ready, busy, valid, bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      $display("FAIL reset_hold: got r=%b b=%b v=%b bcd=%h, need r=1 b=0 v=0 bcd=000",
               ready, busy, valid, bcd);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total_cnt++;
      if ({ready, busy, valid, bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
        $display("FAIL idle_%0d: got r=%b b=%b v=%b bcd=%h, need r=1 b=0 v=0 bcd=000",
                 i, ready, busy, valid, bcd);
      end else pass_cnt++;
    end
    // rst and start together: rst must win
    rst   = 1'b1;
    start = 1'b1;
    bin   = 8'd99;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    total_cnt++;
    if ({ready, busy, valid} !== 3'b100) begin
      $display("FAIL rst_vs_start: got r=%b b=%b v=%b, need r=1 b=0 v=0", ready, busy, valid);
    end else pass_cnt++;
  endtask

  task automatic test_max_product();
    logic [11:0] res;
    int lat, bc;
    logic post;
    convert(8'd225, res, lat, bc, post);
    total_cnt++;
    if (res !== 12'h225) $display("FAIL max_bcd: got %h need 225", res);
    else pass_cnt++;
    total_cnt++;
    if (lat != 8) $display("FAIL max_latency: got %0d need 8", lat);
    else pass_cnt++;
    total_cnt++;
    if (bc != 8) $display("FAIL max_busy_cycles: got %0d need 8", bc);
    else pass_cnt++;
    total_cnt++;
    if (post !== 1'b1) $display("FAIL max_back_to_ready: got %b need 1", post);
    else pass_cnt++;
  endtask

  task automatic test_digit_boundaries();
    logic [7:0]  vals [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199};
    logic [11:0] exps [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199};
    logic [11:0] res;
    int lat, bc;
    logic post;
    for (int i = 0; i < 6; i++) begin
      convert(vals[i], res, lat, bc, post);
      total_cnt++;
      if (res !== exps[i]) $display("FAIL boundary_%0d: got %h need %h", vals[i], res, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sweep();
    logic [11:0] res;
    int lat, bc;
    logic post;
    for (int v = 0; v <= 225; v++) begin
      convert(8'(v), res, lat, bc, post);
      total_cnt++;
      if (res !== ref_bcd(v) || lat != 8)
        $display("FAIL sweep_%0d: got %h lat %0d need %h lat 8", v, res, lat, ref_bcd(v));
      else pass_cnt++;
    end
  endtask

  task automatic test_ignored_start();
    int vcnt;
    logic [11:0] got;
    vcnt = 0;
    got  = 12'hxxx;
    bin   = 8'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i >= 2 && i <= 4) begin
        start = 1'b1;
        bin   = 8'd200 ^ 8'(i);
      end else begin
        start = 1'b0;
      end
      tick();
      if (valid) begin
        vcnt++;
        got = bcd;
      end
    end
    total_cnt++;
    if (vcnt != 1) $display("FAIL ignored_valid_count: got %0d need 1", vcnt);
    else pass_cnt++;
    total_cnt++;
    if (got !== 12'h042) $display("FAIL ignored_result: got %h need 042", got);
    else pass_cnt++;
    total_cnt++;
    if (bcd !== 12'h042) $display("FAIL ignored_hold: got %h need 042", bcd);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int vcnt;
    logic [11:0] res;
    int lat, bc;
    logic post;
    bin   = 8'd144;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({ready, busy, valid, bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      $display("FAIL midreset_now: got r=%b b=%b v=%b bcd=%h, need r=1 b=0 v=0 bcd=000",
               ready, busy, valid, bcd);
    end else pass_cnt++;
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid) vcnt++;
    end
    total_cnt++;
    if (vcnt != 0) $display("FAIL midreset_no_valid: got %0d need 0", vcnt);
    else pass_cnt++;
    convert(8'd36, res, lat, bc, post);
    total_cnt++;
    if (res !== 12'h036 || lat != 8)
      $display("FAIL midreset_next: got %h lat %0d need 036 lat 8", res, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [3] = '{8'd7, 8'd64, 8'd225};
    logic [11:0] exps [3] = '{12'h007, 12'h064, 12'h225};
    logic [11:0] got [3];
    int vc [3];
    int nv, nxt;
    nv  = 0;
    nxt = 1;
    bin   = vals[0];
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid && nv < 3) begin
        got[nv] = bcd;
        vc[nv]  = c;
        nv++;
        if (nv == 3) begin
          start = 1'b0;
          break;
        end
      end
      if (ready && nxt < 3) begin
        bin = vals[nxt];
        nxt++;
      end else if (busy) begin
        bin = 8'hff;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (nv != 3) begin
      $display("FAIL b2b_count: got %0d need 3", nv);
    end else begin
      pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (got[i] !== exps[i]) $display("FAIL b2b_result_%0d: got %h need %h", i, got[i], exps[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (vc[0] != 8) $display("FAIL b2b_first_latency: got %0d need 8", vc[0]);
      else pass_cnt++;
      total_cnt++;
      if (vc[1] - vc[0] != 10 || vc[2] - vc[1] != 10)
        $display("FAIL b2b_spacing: got %0d,%0d need 10,10", vc[1] - vc[0], vc[2] - vc[1]);
      else pass_cnt++;
    end
    tick();
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    test_reset();
    test_max_product();
    test_digit_boundaries();
    test_sweep();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the 4x4 array multiplier. It consumes the 8-bit product and produces three packed BCD digits for display or decoder stages. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. A start/ready/valid handshake frames each conversion.

Parameters:
WIDTH, 8, binary input width (multiplier product width)
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request to convert bin; sampled only when ready=1
bin  input  WIDTH  binary value (multiplier product), sampled on the accepting edge
ready  output  1  high when idle and able to accept start
busy  output  1  high while a conversion is in progress
valid  output  1  one-cycle pulse: bcd holds a newly completed result
bcd  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0] (units), digit 2 in bits [11:8] (hundreds)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state:
  - state=IDLE, shift counter=0, working registers=0.
  - bcd=0, valid=0, busy=0.
  - ready=1, since ready is decoded from state==IDLE.
- States: IDLE, SHIFT, DONE. Encoding is binary, 2 bits.
- IDLE:
  - ready=1, busy=0, valid=0.
  - If start=1 at an edge: load bin into the shift register, clear the BCD scratch register and counter, then go to SHIFT.
  - If start=0: stay in IDLE.
- SHIFT (busy=1, ready=0), each edge:
  - For every BCD scratch digit >= 5, add 3 (combinational, before the shift).
  - Shift {scratch, binreg} left by 1.
  - Increment the counter.
  - On the edge where counter==WIDTH-1: the final shifted scratch value loads into bcd and the state goes to DONE.
- DONE:
  - valid=1 and busy=0 for exactly one cycle.
  - ready=0 (start is ignored), then go to IDLE.
- Latency:
  - Capture edge E0; shifts on E1..E8 (WIDTH=8).
  - valid is high in the cycle following E8, i.e. WIDTH cycles after the capture edge.
  - Throughput: one conversion per WIDTH+2 cycles.
- bcd holds its last result from DONE until the next conversion's final edge. It does not change during SHIFT.
- Handshake:
  - start while busy or in DONE is ignored and is not queued.
  - bin changes after the capture edge have no effect.
  - start held high continuously gives back-to-back conversions, each re-sampling bin in IDLE.
- Arithmetic:
  - The scratch register is 4*DIGITS bits.
  - Add-3 applies per 4-bit digit and never carries across digits.
  - Every result digit is in 0..9.
  - Maximum multiplier product 225 -> bcd = 12'h225.
- Reset mid-conversion: rst asserted during SHIFT or DONE immediately forces the reset state. The partial result is discarded, bcd=0, and no valid pulse occurs.
- Simultaneous rst and start: rst wins and start is not captured.

Decomposition:
- Shared package / include holds:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - BCD adjust threshold (5) and correction constant (3)
  - digit width constant (4)
- One natural sub-module: bcd_digit_adjust.
  - Purely combinational: 4-bit in, 4-bit out; out = in>=5 ? in+3 : in.
  - Instantiated DIGITS times via generate.
- Optional top-level wrapper (not part of this block) pairs the multiplier and this converter; its start is driven from the operand-load strobe.

Test Plan:
- Reset then idle: assert rst, release, hold start=0 for 20 cycles -> ready=1, busy=0, valid=0, bcd=12'h000 throughout.
- Max product: bin=8'd225 (15x15), pulse start -> busy for 8 cycles, valid single-cycle pulse exactly 8 cycles after capture, bcd=12'h225, then ready=1.
- Digit boundaries: convert 0, 9, 10, 99, 100, 199 -> bcd = 12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199. Run an exhaustive 0..225 sweep against a reference model.
- Ignored start / input hold: start bin=8'd42, then during SHIFT pulse start with bin=8'd200 and toggle bin -> single result 12'h042, one valid pulse only.
- Reset mid-conversion: start bin=8'd144, assert rst at the 4th SHIFT cycle -> outputs immediately at reset values, no valid. Next start with bin=8'd36 -> 12'h036.
- Back-to-back: hold start=1 with bin stepping 8'd7, 8'd64, 8'd225 at each IDLE -> results 12'h007, 12'h064, 12'h225, valid pulses spaced 10 cycles apart.
